// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: active-low 7-segment glyphs (gfedcba order)
// and the wrap-counter saturation value.
package counter_pkg;

    typedef enum logic [6:0] {
        GLYPH_0     = 7'h40,
        GLYPH_1     = 7'h79,
        GLYPH_2     = 7'h24,
        GLYPH_3     = 7'h30,
        GLYPH_4     = 7'h19,
        GLYPH_5     = 7'h12,
        GLYPH_6     = 7'h02,
        GLYPH_7     = 7'h78,
        GLYPH_8     = 7'h00,
        GLYPH_9     = 7'h10,
        GLYPH_A     = 7'h08,
        GLYPH_B     = 7'h03,
        GLYPH_C     = 7'h46,
        GLYPH_D     = 7'h21,
        GLYPH_E     = 7'h06,
        GLYPH_F     = 7'h0E,
        GLYPH_BLANK = 7'h7F
    } glyph_e;

    localparam logic [7:0] WRAP_SAT = 8'd255;

endpackage

// File: rtl/hex_decoder.sv
// Single hex nibble to active-low 7-segment glyph (segment order gfedcba).
module hex_decoder
    import counter_pkg::*;
(
    input  logic [3:0] select,
    output logic [6:0] seg_out
);

    always_comb begin
        seg_out = GLYPH_BLANK;
        case (select)
            4'h0: seg_out = GLYPH_0;
            4'h1: seg_out = GLYPH_1;
            4'h2: seg_out = GLYPH_2;
            4'h3: seg_out = GLYPH_3;
            4'h4: seg_out = GLYPH_4;
            4'h5: seg_out = GLYPH_5;
            4'h6: seg_out = GLYPH_6;
            4'h7: seg_out = GLYPH_7;
            4'h8: seg_out = GLYPH_8;
            4'h9: seg_out = GLYPH_9;
            4'hA: seg_out = GLYPH_A;
            4'hB: seg_out = GLYPH_B;
            4'hC: seg_out = GLYPH_C;
            4'hD: seg_out = GLYPH_D;
            4'hE: seg_out = GLYPH_E;
            4'hF: seg_out = GLYPH_F;
            default: seg_out = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/updown_counter_n.sv
// Modulo-(MAX_COUNT+1) up/down counter with load, terminal-count strobe and saturating wrap counter.
// Hex display decoders are built only when UPDOWN_COUNTER_HEX_DISPLAY_EN is defined; otherwise seg_out is blank.
module updown_counter_n
    import counter_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter int              DIGITS    = (WIDTH + 3) / 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    output logic [WIDTH-1:0]      out,
    output logic                  tc,
    output logic [7:0]            wrap_count,
    output logic [7*DIGITS-1:0]   seg_out
);

    localparam logic [WIDTH:0] MAX_X = (WIDTH + 1)'(MAX_COUNT);

    logic [WIDTH-1:0] out_q;
    logic [7:0]       wrap_q;
    logic [WIDTH:0]   inc_w;
    logic [WIDTH:0]   dec_w;
    logic [WIDTH:0]   ld_w;
    logic             at_term;

    // One extra bit lets overflow past MAX_COUNT and borrow below zero be seen directly.
    assign inc_w   = {1'b0, out_q} + (WIDTH + 1)'(1);
    assign dec_w   = {1'b0, out_q} - (WIDTH + 1)'(1);
    assign ld_w    = {1'b0, load_value};
    assign at_term = up ? ({1'b0, out_q} == MAX_X) : (out_q == '0);
    assign tc      = enable & ~load & at_term;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q  <= '0;
            wrap_q <= '0;
        end else if (load) begin
            out_q <= (ld_w > MAX_X) ? MAX_X[WIDTH-1:0] : load_value;
        end else if (enable) begin
            if (up) begin
                out_q <= (inc_w > MAX_X) ? '0 : inc_w[WIDTH-1:0];
            end else begin
                out_q <= dec_w[WIDTH] ? MAX_X[WIDTH-1:0] : dec_w[WIDTH-1:0];
            end
            if (tc && (wrap_q != WRAP_SAT)) begin
                wrap_q <= wrap_q + 8'd1;
            end
        end
    end

    assign out        = out_q;
    assign wrap_count = wrap_q;

`ifdef UPDOWN_COUNTER_HEX_DISPLAY_EN
    localparam int PADW = (4 * DIGITS > WIDTH) ? 4 * DIGITS : WIDTH;

    logic [PADW-1:0] out_pad;
    assign out_pad = PADW'(out_q);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        hex_decoder u_hex_decoder (
            .select  (out_pad[4*k +: 4]),
            .seg_out (seg_out[7*k +: 7])
        );
    end
`else
    assign seg_out = '1;
`endif

endmodule

// File: tb/tb_updown_counter_n.sv
// Self-checking bench: three counters (moduli 256, 100, 10) share stimulus and are compared
// every cycle against a modular-arithmetic reference model.
module tb_updown_counter_n;

    logic       clock = 1'b0;
    logic       reset, enable, up, load;
    logic [7:0] load_value;

    logic [7:0]  out_f,  out_99,  out_9;
    logic        tc_f,   tc_99,   tc_9;
    logic [7:0]  wrap_f, wrap_99, wrap_9;
    logic [13:0] seg_f,  seg_99,  seg_9;

    always #5 clock = ~clock;

    updown_counter_n u_full (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .out(out_f), .tc(tc_f), .wrap_count(wrap_f), .seg_out(seg_f)
    );
    updown_counter_n #(.WIDTH(8), .MAX_COUNT(99)) u_mod99 (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .out(out_99), .tc(tc_99), .wrap_count(wrap_99), .seg_out(seg_99)
    );
    updown_counter_n #(.WIDTH(8), .MAX_COUNT(9)) u_mod9 (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .out(out_9), .tc(tc_9), .wrap_count(wrap_9), .seg_out(seg_9)
    );

    localparam longint unsigned MAXV [3] = '{255, 99, 9};
    longint unsigned m_out  [3];
    longint unsigned m_wrap [3];
    int unsigned     n_checks = 0;
    int unsigned     n_pass   = 0;

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Segment patterns held active-high here, inverted for the active-low display.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] hi [16];
        hi = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return ~hi[d];
    endfunction

    function automatic logic [13:0] exp_seg(input longint unsigned v);
        logic [7:0] b;
        b = v[7:0];
`ifdef UPDOWN_COUNTER_HEX_DISPLAY_EN
        return {glyph(b[7:4]), glyph(b[3:0])};
`else
        return (b == b) ? 14'h3FFF : 14'h0000;
`endif
    endfunction

    function automatic logic exp_tc(input int i);
        logic at;
        at = up ? (m_out[i] == MAXV[i]) : (m_out[i] == 0);
        return enable & ~load & at;
    endfunction

    task automatic check_all();
        check("out_f",   out_f,   m_out[0]);
        check("out_99",  out_99,  m_out[1]);
        check("out_9",   out_9,   m_out[2]);
        check("tc_f",    tc_f,    exp_tc(0));
        check("tc_99",   tc_99,   exp_tc(1));
        check("tc_9",    tc_9,    exp_tc(2));
        check("wrap_f",  wrap_f,  m_wrap[0]);
        check("wrap_99", wrap_99, m_wrap[1]);
        check("wrap_9",  wrap_9,  m_wrap[2]);
        check("seg_f",   seg_f,   exp_seg(m_out[0]));
        check("seg_99",  seg_99,  exp_seg(m_out[1]));
        check("seg_9",   seg_9,   exp_seg(m_out[2]));
    endtask

    // Drive one cycle of inputs, check combinational and registered outputs, then advance the model.
    task automatic step(input logic r, input logic l, input logic e, input logic u, input logic [7:0] lv);
        longint unsigned n_out [3];
        longint unsigned n_wrap [3];
        reset = r; load = l; enable = e; up = u; load_value = lv;
        #1;
        check_all();
        for (int i = 0; i < 3; i++) begin
            n_out[i]  = m_out[i];
            n_wrap[i] = m_wrap[i];
            if (r) begin
                n_out[i]  = 0;
                n_wrap[i] = 0;
            end else if (l) begin
                n_out[i] = (lv > MAXV[i]) ? MAXV[i] : longint'(lv);
            end else if (e) begin
                if (exp_tc(i) && m_wrap[i] < 255) n_wrap[i] = m_wrap[i] + 1;
                if (u) n_out[i] = (m_out[i] + 1) % (MAXV[i] + 1);
                else   n_out[i] = (m_out[i] + MAXV[i]) % (MAXV[i] + 1);
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            m_out[i]  = n_out[i];
            m_wrap[i] = n_wrap[i];
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; enable = 1'b0; up = 1'b1; load_value = '0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            m_out[i]  = 0;
            m_wrap[i] = 0;
        end

        // Reset state, including tc low while reset holds out at 0 counting up.
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);

        // Full-range count up: 256 edges returns to 0 with exactly one wrap.
        for (int n = 0; n < 256; n++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        check("full_256_out",  out_f,  8'd0);
        check("full_256_wrap", wrap_f, 8'd1);

        // Count down from 0 wraps to MAX_COUNT.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("down_wrap_out9",  out_9,  8'd9);
        check("down_wrap_wrap9", wrap_9, 8'd1);
        for (int n = 0; n < 12; n++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Load above MAX_COUNT clamps; load with enable at terminal leaves wrap_count alone.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd9);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'd200);
        check("load_clamp_99", out_99, 8'd99);
        check("load_clamp_9",  out_9,  8'd9);
        check("load_full",     out_f,  8'd200);

        // Reset together with load.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd57);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'd57);
        check("rst_over_load", out_f, 8'd0);

        // Display pattern for 0x3C.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Direction changes every cycle.
        for (int n = 0; n < 20; n++) step(1'b0, 1'b0, 1'b1, n[0], 8'h00);

        // Over 300 wraps of the modulo-10 counter: wrap_count saturates.
        for (int n = 0; n < 3010; n++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        check("sat_wrap9", wrap_9, 8'd255);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
